// File: rtl/nvram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nvram_pkg
// Brief    : Shared types and constants for the NVRAM upload reader.
// Revision : 1.0
// ============================================================================
package nvram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAUSE   = 3'd1,
        READY   = 3'd2,
        FETCH   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [7:0] FILL_BYTE     = 8'hFF;
    localparam logic [7:0] DEFAULT_INDEX = 8'd4;

endpackage
`default_nettype wire

// File: rtl/nvram_upload_if.sv
`default_nettype none
// ============================================================================
// Module   : nvram_upload_if
// Brief    : HPS ioctl upload, RAM read port and CPU pause handshake bundle.
// Revision : 1.0
// ============================================================================
interface nvram_upload_if #(
    parameter int RAM_AW = 10
);
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_q;
    logic              pause_req;
    logic              pause_ack;
    logic [RAM_AW:0]   byte_count;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_q, pause_ack,
        output ioctl_din, ioctl_wait, ram_addr, ram_rd, pause_req, byte_count
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_q, pause_ack,
        input  ioctl_din, ioctl_wait, ram_addr, ram_rd, pause_req, byte_count
    );
endinterface
`default_nettype wire

// File: rtl/rd_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rd_lat_pipe
// Brief    : DEPTH-deep valid shift register marking when RAM read data lands.
// Revision : 1.0
// ============================================================================
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_valid
);
    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst || i_flush) r_sr <= '0;
                else                r_sr <= i_valid;
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst || i_flush) r_sr <= '0;
                else                r_sr <= {r_sr[DEPTH-2:0], i_valid};
            end
        end
    endgenerate

    assign o_valid = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/nvram_upload.sv
`default_nettype none
// ============================================================================
// Module   : nvram_upload
// Brief    : Serves HPS upload reads from work RAM while the game CPU is paused.
// Revision : 1.0
// ============================================================================
module nvram_upload
    import nvram_pkg::*;
#(
    parameter logic [7:0] INDEX  = DEFAULT_INDEX,
    parameter int         RAM_AW = 10,
    parameter int         SIZE   = 1024,
    parameter int         RD_LAT = 1
) (
    input  logic           clk_sys,
    input  logic           reset,
    nvram_upload_if.slave  bus
);
    localparam logic [24:0]     c_size_addr = 25'(SIZE);
    localparam logic [RAM_AW:0] c_size_cnt  = (RAM_AW+1)'(SIZE);
    localparam logic [RAM_AW:0] c_cnt_one   = (RAM_AW+1)'(1);

    state_t            r_state;
    logic              r_pending;
    logic              r_oor;
    logic [7:0]        r_din;
    logic              r_wait;
    logic [RAM_AW-1:0] r_ram_addr;
    logic              r_ram_rd;
    logic              r_pause_req;
    logic [RAM_AW:0]   r_count;

    logic w_sel;
    logic w_req_oor;
    logic w_cap;
    logic w_abort;

    assign w_sel     = bus.ioctl_upload && (bus.ioctl_index == INDEX);
    assign w_req_oor = bus.ioctl_addr >= c_size_addr;
    // Session ends on sel low in any active state; IDLE/RELEASE ignore it.
    assign w_abort   = !w_sel && (r_state == PAUSE || r_state == READY || r_state == FETCH);

    // Flushing in RELEASE drops the strobe of an aborted fetch.
    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_lat (
        .clk     (clk_sys),
        .rst     (reset),
        .i_flush (r_state == RELEASE),
        .i_valid (r_ram_rd),
        .o_valid (w_cap)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_oor       <= 1'b0;
            r_din       <= 8'h00;
            r_wait      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_rd    <= 1'b0;
            r_pause_req <= 1'b0;
            r_count     <= '0;
        end else begin
            r_ram_rd <= 1'b0;
            if (w_abort) begin
                r_state     <= RELEASE;
                r_wait      <= 1'b0;
                r_pause_req <= 1'b0;
                r_pending   <= 1'b0;
            end else begin
                case (r_state)
                    // Level start also picks up a sel that rose during RELEASE.
                    IDLE: begin
                        if (w_sel) begin
                            r_state     <= PAUSE;
                            r_pause_req <= 1'b1;
                            r_wait      <= 1'b1;
                            r_count     <= '0;
                            r_pending   <= bus.ioctl_rd;
                            if (bus.ioctl_rd) begin
                                r_ram_addr <= bus.ioctl_addr[RAM_AW-1:0];
                                r_oor      <= w_req_oor;
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.pause_ack) begin
                            r_pending <= 1'b0;
                            if (r_pending) begin
                                r_state  <= FETCH;
                                r_ram_rd <= !r_oor;
                            end else begin
                                r_state <= READY;
                                r_wait  <= 1'b0;
                            end
                        end
                    end
                    READY: begin
                        if (bus.ioctl_rd) begin
                            r_state    <= FETCH;
                            r_wait     <= 1'b1;
                            r_ram_addr <= bus.ioctl_addr[RAM_AW-1:0];
                            r_oor      <= w_req_oor;
                            r_ram_rd   <= !w_req_oor;
                        end
                    end
                    FETCH: begin
                        if (r_oor || w_cap) begin
                            r_din   <= r_oor ? FILL_BYTE : bus.ram_q;
                            r_wait  <= 1'b0;
                            r_state <= READY;
                            if (r_count != c_size_cnt) r_count <= r_count + c_cnt_one;
                        end
                    end
                    RELEASE: begin
                        if (!bus.pause_ack) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ioctl_din  = r_din;
    assign bus.ioctl_wait = r_wait;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_rd     = r_ram_rd;
    assign bus.pause_req  = r_pause_req;
    assign bus.byte_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_nvram_upload.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nvram_upload
// Brief    : Directed self-checking bench for nvram_upload with RD_LAT=2.
// Revision : 1.0
// ============================================================================
module tb_nvram_upload;
    localparam int RAM_AW = 10;
    localparam int SIZE   = 1024;
    localparam int RD_LAT = 2;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    nvram_upload_if #(.RAM_AW(RAM_AW)) bus ();

    nvram_upload #(
        .INDEX  (8'd4),
        .RAM_AW (RAM_AW),
        .SIZE   (SIZE),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Two-stage RAM model; 8'hEE marks data not backed by a read.
    logic [7:0] mem [0:SIZE-1];
    logic [7:0] r_d1;
    always @(posedge clk_sys) begin
        r_d1      <= bus.ram_rd ? mem[bus.ram_addr] : 8'hEE;
        bus.ram_q <= r_d1;
    end

    int                rd_pulses = 0;
    logic [RAM_AW-1:0] last_rd_addr;
    always @(negedge clk_sys) begin
        if (bus.ram_rd === 1'b1) begin
            rd_pulses++;
            last_rd_addr = bus.ram_addr;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_read(input logic [24:0] addr, output logic [7:0] din, output int lat);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = addr;
        tick();
        bus.ioctl_rd   = 1'b0;
        lat = 0;
        while (bus.ioctl_wait === 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        din = bus.ioctl_din;
    endtask

    task automatic start_session();
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = 8'd4;
        tick();
        tick();
        bus.pause_ack = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_session();
        bus.ioctl_upload = 1'b0;
        tick();
        bus.pause_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.ioctl_din, bus.ioctl_wait, bus.ram_rd, bus.pause_req} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: din=%h wait=%b ram_rd=%b pause_req=%b want 00/0/0/0",
                     bus.ioctl_din, bus.ioctl_wait, bus.ram_rd, bus.pause_req);
        end
        checks++;
        if ({bus.ram_addr, bus.byte_count} !== 21'h0) begin
            errors++;
            $display("FAIL reset_counters: ram_addr=%h byte_count=%0d want 0/0", bus.ram_addr, bus.byte_count);
        end
    endtask

    task automatic test_pause();
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = 8'd4;
        tick();
        checks++;
        if ({bus.pause_req, bus.ioctl_wait} !== 2'b11) begin
            errors++;
            $display("FAIL pause_enter: pause_req=%b wait=%b want 1/1", bus.pause_req, bus.ioctl_wait);
        end
        tick();
        tick();
        checks++;
        if (bus.ioctl_wait !== 1'b1 || rd_pulses != 0) begin
            errors++;
            $display("FAIL pause_hold: wait=%b ram_rd_pulses=%0d want 1/0", bus.ioctl_wait, rd_pulses);
        end
        bus.pause_ack = 1'b1;
        tick();
        checks++;
        if (bus.ioctl_wait !== 1'b0 || bus.pause_req !== 1'b1 || rd_pulses != 0) begin
            errors++;
            $display("FAIL pause_ready: wait=%b pause_req=%b pulses=%0d want 0/1/0",
                     bus.ioctl_wait, bus.pause_req, rd_pulses);
        end
    endtask

    task automatic test_read();
        logic [7:0] d;
        int         lat;
        int         p0;
        p0 = rd_pulses;
        do_read(25'h010, d, lat);
        checks++;
        if (d !== 8'h5A || lat != 3) begin
            errors++;
            $display("FAIL read_0x010: din=%h lat=%0d want 5a/3", d, lat);
        end
        checks++;
        if (rd_pulses - p0 != 1 || last_rd_addr !== 10'h010) begin
            errors++;
            $display("FAIL read_ram_port: pulses=%0d addr=%h want 1/010", rd_pulses - p0, last_rd_addr);
        end
        checks++;
        if (bus.byte_count !== 11'd1) begin
            errors++;
            $display("FAIL read_count: byte_count=%0d want 1", bus.byte_count);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] d;
        int         lat;
        int         p0;
        p0 = rd_pulses;
        do_read(25'h400, d, lat);
        checks++;
        if (d !== 8'hFF || lat != 1) begin
            errors++;
            $display("FAIL oor_0x400: din=%h lat=%0d want ff/1", d, lat);
        end
        do_read(25'h1000010, d, lat);
        checks++;
        if (d !== 8'hFF || lat != 1 || rd_pulses != p0) begin
            errors++;
            $display("FAIL oor_high_bits: din=%h lat=%0d pulses=%0d want ff/1/0", d, lat, rd_pulses - p0);
        end
        checks++;
        if (bus.byte_count !== 11'd3) begin
            errors++;
            $display("FAIL oor_count: byte_count=%0d want 3", bus.byte_count);
        end
    endtask

    task automatic test_pending();
        int p0;
        end_session();
        p0 = rd_pulses;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_rd     = 1'b1;
        bus.ioctl_addr   = 25'h005;
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ioctl_wait !== 1'b1 || rd_pulses != p0) begin
            errors++;
            $display("FAIL pending_hold: wait=%b pulses=%0d want 1/0", bus.ioctl_wait, rd_pulses - p0);
        end
        bus.pause_ack = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL pending_fetch_wait: wait=%b want 1", bus.ioctl_wait);
        end
        tick();
        checks++;
        if (bus.ioctl_wait !== 1'b0 || bus.ioctl_din !== mem[5] || bus.byte_count !== 11'd1 ||
            rd_pulses - p0 != 1) begin
            errors++;
            $display("FAIL pending_data: wait=%b din=%h count=%0d pulses=%0d want 0/%h/1/1",
                     bus.ioctl_wait, bus.ioctl_din, bus.byte_count, rd_pulses - p0, mem[5]);
        end
    endtask

    task automatic test_sequential();
        logic [7:0] d;
        int         lat;
        end_session();
        start_session();
        for (int i = 0; i < SIZE; i++) begin
            do_read(25'(i), d, lat);
            checks++;
            if (d !== mem[i] || lat != 3) begin
                errors++;
                $display("FAIL seq_read[%0d]: din=%h lat=%0d want %h/3", i, d, lat, mem[i]);
            end
        end
        checks++;
        if (bus.byte_count !== 11'd1024) begin
            errors++;
            $display("FAIL seq_count_full: byte_count=%0d want 1024", bus.byte_count);
        end
        do_read(25'h000, d, lat);
        do_read(25'h3FF, d, lat);
        checks++;
        if (d !== mem[1023] || bus.byte_count !== 11'd1024) begin
            errors++;
            $display("FAIL seq_saturate: din=%h count=%0d want %h/1024", d, bus.byte_count, mem[1023]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        int         lat;
        end_session();
        start_session();
        do_read(25'h010, d, lat);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'h020;
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        bus.ioctl_upload = 1'b0;
        tick();
        checks++;
        if (bus.ioctl_wait !== 1'b0 || bus.pause_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: wait=%b pause_req=%b want 0/0", bus.ioctl_wait, bus.pause_req);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.ioctl_din !== 8'h5A || bus.byte_count !== 11'd1) begin
            errors++;
            $display("FAIL abort_discard: din=%h count=%0d want 5a/1", bus.ioctl_din, bus.byte_count);
        end
        // New session request while ack still high must wait for IDLE.
        bus.ioctl_upload = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.pause_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_holdoff: pause_req=%b want 0", bus.pause_req);
        end
        bus.pause_ack = 1'b0;
        tick();
        checks++;
        if (bus.pause_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: pause_req=%b want 0", bus.pause_req);
        end
        tick();
        checks++;
        if (bus.pause_req !== 1'b1 || bus.byte_count !== 11'd0) begin
            errors++;
            $display("FAIL abort_restart: pause_req=%b count=%0d want 1/0", bus.pause_req, bus.byte_count);
        end
        bus.ioctl_upload = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_other_index();
        int p0;
        p0 = rd_pulses;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = 8'd0;
        tick();
        tick();
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'h010;
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.pause_req !== 1'b0 || bus.ioctl_wait !== 1'b0 || rd_pulses != p0) begin
            errors++;
            $display("FAIL other_index: pause_req=%b wait=%b pulses=%0d want 0/0/0",
                     bus.pause_req, bus.ioctl_wait, rd_pulses - p0);
        end
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd4;
        tick();
    endtask

    task automatic test_reset_in_fetch();
        logic [7:0] d;
        int         lat;
        start_session();
        do_read(25'h011, d, lat);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'h012;
        tick();
        bus.ioctl_rd = 1'b0;
        checks++;
        if (bus.ioctl_wait !== 1'b1 || bus.ioctl_din !== mem[17]) begin
            errors++;
            $display("FAIL rst_fetch_pre: wait=%b din=%h want 1/%h", bus.ioctl_wait, bus.ioctl_din, mem[17]);
        end
        reset            = 1'b1;
        bus.ioctl_upload = 1'b0;
        tick();
        checks++;
        if ({bus.ioctl_din, bus.ioctl_wait, bus.ram_rd, bus.pause_req} !== 11'h000 ||
            {bus.ram_addr, bus.byte_count} !== 21'h0) begin
            errors++;
            $display("FAIL rst_fetch: din=%h wait=%b ram_rd=%b pause_req=%b addr=%h count=%0d want all 0",
                     bus.ioctl_din, bus.ioctl_wait, bus.ram_rd, bus.pause_req, bus.ram_addr, bus.byte_count);
        end
        reset         = 1'b0;
        bus.pause_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = 8'(i * 7 + 3);
        mem[16] = 8'h5A;
        reset            = 1'b1;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        bus.pause_ack    = 1'b0;

        test_reset();
        test_pause();
        test_read();
        test_out_of_range();
        test_pending();
        test_sequential();
        test_abort();
        test_other_index();
        test_reset_in_fetch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/nvram_upload.md
Name: nvram_upload

Overview:
- Reader side of the HPS ioctl file channel. Download writes ROM bytes into the core; this block serves an upload and returns bytes from core RAM (hiscore/NVRAM region) to the HPS.
- Sits between hps_io upload signals and a dedicated read port of the game's dual-port work RAM.
- Pauses the game CPU for the whole session so the snapshot is coherent.

Parameters:
- INDEX, 8'd4, ioctl_index value that selects this block; other indices are ignored.
- RAM_AW, 10, RAM read-port address width.
- SIZE, 1024, valid image length in bytes (SIZE ≤ 2**RAM_AW).
- RD_LAT, 1, RAM read latency in clk_sys cycles from ram_rd to valid ram_q (1..3).

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_upload  in  1  HPS upload session active (level).
- ioctl_index  in  8  file index of the session.
- ioctl_rd  in  1  one-cycle strobe: HPS requests the byte at ioctl_addr.
- ioctl_addr  in  25  byte address of the request.
- ioctl_din  out  8  returned byte; stable from wait release until the next accepted strobe.
- ioctl_wait  out  1  stall to HPS; HPS issues no ioctl_rd while high.
- ram_addr  out  RAM_AW  RAM read address.
- ram_rd  out  1  one-cycle RAM read enable.
- ram_q  in  8  RAM read data.
- pause_req  out  1  freeze request to the game CPU.
- pause_ack  in  1  CPU frozen (level).
- byte_count  out  RAM_AW+1  bytes served in the current session.

Behaviour:
- Interface: one clock, clk_sys; reset is synchronous and active-high.
- Reset values: ioctl_din=8'h00, ioctl_wait=0, ram_rd=0, ram_addr=0, pause_req=0, byte_count=0, state=IDLE. This applies regardless of state, including mid-fetch.
- sel = ioctl_upload & (ioctl_index==INDEX).
- IDLE:
  - On sel rising, go to PAUSE, set pause_req=1 and ioctl_wait=1, clear byte_count.
  - An ioctl_rd in the same cycle is latched as pending.
- PAUSE:
  - Hold until pause_ack=1, then go to READY.
  - If a request is pending, go straight to FETCH with the latched address.
  - ioctl_wait stays 1 throughout PAUSE.
- READY:
  - ioctl_wait=0.
  - On ioctl_rd, latch ioctl_addr, set ioctl_wait=1 in the next cycle, go to FETCH.
- FETCH, in-range (addr < SIZE):
  - ram_addr=addr[RAM_AW-1:0], ram_rd=1 for exactly one cycle.
  - A latency counter counts RD_LAT cycles, then ram_q is captured into ioctl_din and the state returns to READY.
  - Total: ioctl_wait high for RD_LAT+1 cycles after the strobe cycle.
- FETCH, out-of-range (addr ≥ SIZE, including ioctl_addr[24:RAM_AW]≠0):
  - No RAM access; ioctl_din=8'hFF after 1 cycle.
- byte_count:
  - Increments on each data return.
  - Saturates at SIZE; the counter does not wrap.
- ioctl_rd received while in FETCH or PAUSE: protocol violation.
  - It is ignored, except for the single latch in the IDLE→PAUSE cycle.
- sel falls (any state): next cycle goes to RELEASE.
  - Any fetch in flight is aborted: its data is discarded and its byte is not counted.
  - ioctl_wait=0.
- RELEASE: pause_req=0; wait for pause_ack=0, then go to IDLE.
- A new sel rising while in RELEASE is held off until IDLE.
- pause_ack dropping unexpectedly during READY/FETCH: no action; pause_req stays asserted.

Decomposition:
- Shared package nvram_pkg:
  - state enum {IDLE, PAUSE, READY, FETCH, RELEASE}
  - FILL_BYTE=8'hFF
  - default INDEX constant
- Sub-module rd_lat_pipe: RD_LAT-deep valid shift register producing the capture strobe. It is reused by a future download-to-NVRAM writer.

Test Plan:
1. Reset, then upload with index 4, pause_ack 3 cycles later → pause_req=1 next cycle; ioctl_wait=1 until 1 cycle after ack; no ram_rd before ack.
2. RAM[0x010]=8'h5A, RD_LAT=2, rd addr 0x010 → ram_rd one cycle with ram_addr=0x010; ioctl_din=8'h5A and ioctl_wait=0 exactly 3 cycles after the strobe; byte_count=1.
3. rd addr 0x400 (SIZE=1024) → no ram_rd; ioctl_din=8'hFF after 1 cycle.
4. Sequential reads 0..1023, then 2 extra → data matches RAM image; byte_count saturates at 1024.
5. Upload drops 1 cycle after a strobe (mid-fetch) → ioctl_din unchanged; byte_count unchanged; ioctl_wait=0; pause_req=0 next cycle; IDLE after ack falls.
6. Upload with index 0 (ROM) → no pause_req, no ram_rd. Separately, reset asserted during FETCH → all outputs at reset values next cycle.
